// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// values, datapath select codes and fault codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that hold a memory access open and are subject to the ready timeout
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Combinational instruction decode: picks the state that follows DECODE and flags
// opcode/funct combinations the datapath cannot execute.
module mc_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output state_t     o_next_state,
    output logic       o_illegal
);

    always_comb begin
        o_next_state = S_HALT;
        o_illegal    = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                if (i_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
                    o_next_state = S_EXEC;
                    o_illegal    = 1'b0;
                end
            end
            OP_LW, OP_SW: begin
                o_next_state = S_MEMADR;
                o_illegal    = 1'b0;
            end
            OP_BEQ: begin
                o_next_state = S_BRANCH;
                o_illegal    = 1'b0;
            end
            OP_J: begin
                o_next_state = S_JUMP;
                o_illegal    = 1'b0;
            end
            OP_ADDI: begin
                o_next_state = S_ADDIEX;
                o_illegal    = 1'b0;
            end
            default: begin
                o_next_state = S_HALT;
                o_illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences FETCH..WB, drives datapath selects and
// enables, times out stalled memory accesses and counts retired instructions.
module mc_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_iord,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_mem_to_reg,
    output logic             o_reg_dst,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_pc_source,
    output logic [3:0]       o_state,
    output logic             o_halted,
    output logic [1:0]       o_fault,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t           r_state;
    state_t           w_next_state;
    state_t           w_dec_state;
    logic             w_dec_illegal;
    logic [7:0]       r_wait;
    logic [7:0]       w_next_wait;
    logic [1:0]       r_fault;
    logic [1:0]       w_next_fault;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_retire;
    logic             w_timeout;
    ctrl_t            w_ctrl;
    ctrl_t            w_ctrl_gated;

    mc_op_decode u_op_decode (
        .i_opcode     (i_opcode),
        .i_funct      (i_funct),
        .o_next_state (w_dec_state),
        .o_illegal    (w_dec_illegal)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_FETCH;
            r_wait        <= '0;
            r_fault       <= FAULT_NONE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_next_wait;
            r_fault <= w_next_fault;
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_ctrl       = '0;
        w_next_state = r_state;
        w_next_fault = r_fault;
        w_retire     = 1'b0;
        // Completing the access on the limit cycle takes priority over the timeout
        w_timeout    = !i_mem_ready && (r_wait == WAIT_LAST);

        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
                if (i_mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_en    = 1'b1;
                    w_next_state    = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_next_fault = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_IMM_SH;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next_state     = w_dec_state;
                if (w_dec_illegal) begin
                    w_next_fault = FAULT_ILLEGAL;
                end
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next_state     = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                if (i_mem_ready) begin
                    w_next_state = S_MEMWB;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_next_fault = FAULT_TIMEOUT;
                end
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_retire          = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (i_mem_ready) begin
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                    w_next_fault = FAULT_TIMEOUT;
                end
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_next_state     = S_RWB;
            end
            S_RWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                w_retire         = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_op    = ALUOP_SUB;
                w_ctrl.pc_source = PCSRC_ALUOUT;
                w_ctrl.pc_en     = i_zero;
                w_retire         = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_source = PCSRC_JUMP;
                w_ctrl.pc_en     = 1'b1;
                w_retire         = 1'b1;
            end
            S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_next_state     = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
                w_retire         = 1'b1;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_HALT;
                w_next_fault = FAULT_ILLEGAL;
            end
        endcase

        if (w_retire) begin
            w_next_state = S_FETCH;
        end
        if (r_fault != FAULT_NONE) begin
            w_next_fault = r_fault;
        end
    end

    // Counter restarts on entry to a memory state because any state change yields zero
    always_comb begin
        w_next_wait = '0;
        if (is_mem_state(r_state) && !i_mem_ready && (w_next_state == r_state)) begin
            w_next_wait = r_wait + 8'd1;
        end
    end

    assign w_ctrl_gated  = i_rst ? '0 : w_ctrl;

    assign o_pc_en       = w_ctrl_gated.pc_en;
    assign o_iord        = w_ctrl_gated.iord;
    assign o_mem_read    = w_ctrl_gated.mem_read;
    assign o_mem_write   = w_ctrl_gated.mem_write;
    assign o_ir_write    = w_ctrl_gated.ir_write;
    assign o_mem_to_reg  = w_ctrl_gated.mem_to_reg;
    assign o_reg_dst     = w_ctrl_gated.reg_dst;
    assign o_reg_write   = w_ctrl_gated.reg_write;
    assign o_alu_src_a   = w_ctrl_gated.alu_src_a;
    assign o_alu_src_b   = w_ctrl_gated.alu_src_b;
    assign o_alu_op      = w_ctrl_gated.alu_op;
    assign o_pc_source   = w_ctrl_gated.pc_source;
    assign o_state       = r_state;
    assign o_halted      = (r_state == S_HALT);
    assign o_fault       = r_fault;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for mc_ctrl_fsm: each stimulus cycle queues the
// expected outputs, and a negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;

    localparam int PC_EN = 14, IORD = 13, MRD = 12, MWR = 11, IRW = 10;
    localparam int M2R = 9, RDST = 8, RWR = 7, SRCA = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
    logic        reg_dst, reg_write, alu_src_a, halted;
    logic [1:0]  alu_src_b, alu_op, pc_source, fault;
    logic [3:0]  state;
    logic [31:0] instr_count;

    typedef struct packed {
        logic [14:0] v;
        logic [14:0] m;
    } ctl_t;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [14:0] cv;
        logic [14:0] cm;
        logic        halted;
        logic [1:0]  fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mc_ctrl_fsm #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .i_zero        (zero),
        .i_mem_ready   (mem_ready),
        .o_pc_en       (pc_en),
        .o_iord        (iord),
        .o_mem_read    (mem_read),
        .o_mem_write   (mem_write),
        .o_ir_write    (ir_write),
        .o_mem_to_reg  (mem_to_reg),
        .o_reg_dst     (reg_dst),
        .o_reg_write   (reg_write),
        .o_alu_src_a   (alu_src_a),
        .o_alu_src_b   (alu_src_b),
        .o_alu_op      (alu_op),
        .o_pc_source   (pc_source),
        .o_state       (state),
        .o_halted      (halted),
        .o_fault       (fault),
        .o_instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Expected control word per state; the mask keeps only the fields that state defines
    function automatic ctl_t exp_ctrl(input int st, input bit rdy, input bit z);
        ctl_t c;
        c.v = '0;
        c.m = 15'h5C80;
        case (st)
            0: begin
                c.m[IORD] = 1'b1; c.m[6:0] = '1;
                c.v[MRD] = 1'b1; c.v[5:4] = 2'b01;
                if (rdy) begin c.v[IRW] = 1'b1; c.v[PC_EN] = 1'b1; end
            end
            1: begin c.m[6:2] = '1; c.v[5:4] = 2'b11; end
            2, 10: begin c.m[6:2] = '1; c.v[SRCA] = 1'b1; c.v[5:4] = 2'b10; end
            6: begin c.m[6:2] = '1; c.v[SRCA] = 1'b1; c.v[3:2] = 2'b10; end
            3: begin c.m[IORD] = 1'b1; c.v[IORD] = 1'b1; c.v[MRD] = 1'b1; end
            5: begin c.m[IORD] = 1'b1; c.v[IORD] = 1'b1; c.v[MWR] = 1'b1; end
            4: begin c.m[M2R] = 1'b1; c.m[RDST] = 1'b1; c.v[RWR] = 1'b1; c.v[M2R] = 1'b1; end
            7: begin c.m[M2R] = 1'b1; c.m[RDST] = 1'b1; c.v[RWR] = 1'b1; c.v[RDST] = 1'b1; end
            11: begin c.m[M2R] = 1'b1; c.m[RDST] = 1'b1; c.v[RWR] = 1'b1; end
            8: begin
                c.m[6:0] = '1; c.v[SRCA] = 1'b1; c.v[3:2] = 2'b01; c.v[1:0] = 2'b01;
                c.v[PC_EN] = z;
            end
            9: begin c.m[1:0] = '1; c.v[1:0] = 2'b10; c.v[PC_EN] = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input bit rdy, input bit z, input int st,
                       input logic [1:0] flt, input logic [31:0] cnt);
        exp_t e;
        ctl_t c;
        @(posedge clk);
        #1;
        rst = 1'b0; opcode = op; funct = fn; mem_ready = rdy; zero = z;
        c = exp_ctrl(st, rdy, z);
        e.name = nm; e.st = 4'(st); e.cv = c.v; e.cm = c.m;
        e.halted = (st == 12); e.fault = flt; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic rcyc(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b1;
        e.name = nm; e.st = 4'd0; e.cv = '0; e.cm = '1;
        e.halted = 1'b0; e.fault = 2'b00; e.cnt = 32'd0;
        sb.push_back(e);
    endtask

    // States packed as nibbles, first state in the most significant used nibble
    task automatic seq(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input bit z, input int n, input logic [31:0] sts,
                       input logic [31:0] cnt);
        for (int i = 0; i < n; i++) begin
            cyc(nm, op, fn, 1'b1, z, int'(sts[4*(n-1-i) +: 4]), 2'b00, cnt);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [14:0] act;
            e = sb.pop_front();
            act = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
            checks++;
            if (state !== e.st || (act & e.cm) !== (e.cv & e.cm) || halted !== e.halted ||
                fault !== e.fault || instr_count !== e.cnt) begin
                errors++;
                $display("FAIL %s: got state=%0d ctrl=%h halted=%b fault=%b cnt=%h, want state=%0d ctrl=%h mask=%h halted=%b fault=%b cnt=%h",
                         e.name, state, act, halted, fault, instr_count,
                         e.st, e.cv, e.cm, e.halted, e.fault, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        cyc("fetch_pre", 6'h00, 6'h20, 1'b0, 1'b0, 0, 2'b00, 32'd0);
        repeat (3) rcyc("reset");

        seq("add",    6'h00, 6'h20, 1'b0, 4, 32'h0167,  32'd0);
        seq("lw",     6'h23, 6'h00, 1'b0, 5, 32'h01234, 32'd1);
        seq("sw",     6'h2B, 6'h00, 1'b0, 4, 32'h0125,  32'd2);
        seq("beq_t",  6'h04, 6'h00, 1'b1, 3, 32'h018,   32'd3);
        seq("beq_nt", 6'h04, 6'h00, 1'b0, 3, 32'h018,   32'd4);
        seq("j",      6'h02, 6'h00, 1'b0, 3, 32'h019,   32'd5);

        for (int i = 0; i < 4; i++) cyc("addi_fwait", 6'h08, 6'h00, 1'b0, 1'b0, 0, 2'b00, 32'd6);
        seq("addi",   6'h08, 6'h00, 1'b0, 4, 32'h01AB,  32'd6);

        seq("sw_w",   6'h2B, 6'h00, 1'b0, 3, 32'h012,   32'd7);
        cyc("sw_wait", 6'h2B, 6'h00, 1'b0, 1'b0, 5, 2'b00, 32'd7);
        cyc("sw_wait", 6'h2B, 6'h00, 1'b0, 1'b0, 5, 2'b00, 32'd7);
        cyc("sw_done", 6'h2B, 6'h00, 1'b1, 1'b0, 5, 2'b00, 32'd7);

        seq("lw_lim", 6'h23, 6'h00, 1'b0, 3, 32'h012,   32'd8);
        for (int i = 0; i < 14; i++) cyc("lw_lim_wait", 6'h23, 6'h00, 1'b0, 1'b0, 3, 2'b00, 32'd8);
        cyc("lw_lim_rdy", 6'h23, 6'h00, 1'b1, 1'b0, 3, 2'b00, 32'd8);
        cyc("lw_lim_wb",  6'h23, 6'h00, 1'b1, 1'b0, 4, 2'b00, 32'd8);

        seq("lw_to",  6'h23, 6'h00, 1'b0, 3, 32'h012,   32'd9);
        for (int i = 0; i < 15; i++) cyc("lw_to_wait", 6'h23, 6'h00, 1'b0, 1'b0, 3, 2'b00, 32'd9);
        for (int i = 0; i < 3; i++) cyc("halt_to", 6'h23, 6'h00, i[0], 1'b1, 12, 2'b10, 32'd9);

        rcyc("reset_to");
        seq("ill_op", 6'h3F, 6'h00, 1'b0, 2, 32'h01, 32'd0);
        cyc("ill_op_halt", 6'h3F, 6'h00, 1'b1, 1'b0, 12, 2'b01, 32'd0);
        cyc("ill_op_halt", 6'h00, 6'h20, 1'b1, 1'b0, 12, 2'b01, 32'd0);

        rcyc("reset_ill");
        seq("j2",     6'h02, 6'h00, 1'b0, 3, 32'h019, 32'd0);
        seq("ill_fn", 6'h00, 6'h00, 1'b0, 2, 32'h01,  32'd1);
        cyc("ill_fn_halt", 6'h00, 6'h00, 1'b1, 1'b0, 12, 2'b01, 32'd1);
        cyc("ill_fn_halt", 6'h00, 6'h00, 1'b1, 1'b0, 12, 2'b01, 32'd1);

        rcyc("reset_fn");
        cyc("wrap_pre", 6'h08, 6'h00, 1'b0, 1'b0, 0, 2'b00, 32'd0);
        @(negedge clk);
        #1;
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        seq("addi_wrap", 6'h08, 6'h00, 1'b0, 4, 32'h01AB, 32'hFFFF_FFFF);
        cyc("wrap_post", 6'h00, 6'h20, 1'b0, 1'b0, 0, 2'b00, 32'd0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit that sequences the shared single-memory / single-ALU MIPS datapath inside CPU.
- Decodes opcode/funct held in IR and steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Drives all datapath mux selects and write enables, handles a memory ready handshake with timeout, and counts retired instructions.

Parameters:
- WAIT_MAX, 15, maximum cycles a memory state waits for mem_ready before faulting (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC load = PCWrite | (PCWriteCond & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- halted  out  1  FSM is in HALT.
- fault  out  2  00 = none, 01 = illegal opcode/funct, 10 = memory timeout.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset is asynchronous, active-high. On assertion: state = FETCH, wait counter = 0, instr_count = 0, fault = 00. While Reset is high, every control output is 0; state and halted reflect the reset values.
- Moore decode from the state register, except where noted below.
- FETCH (0): mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write and pc_en are asserted only when mem_ready = 1. Moves to DECODE when mem_ready = 1.
- DECODE (1): alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC, but only for funct ∈ {100000, 100010, 100100, 100101, 101010}.
  - 100011 and 101011 → MEMADR.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - 001000 → ADDIEX.
  - Anything else → HALT with fault = 01.
- MEMADR (2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD (3): mem_read = 1, iord = 1. Moves to MEMWB when mem_ready = 1.
- MEMWB (4): reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retires.
- MEMWR (5): mem_write = 1, iord = 1. Retires when mem_ready = 1.
- EXEC (6): alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state RWB.
- RWB (7): reg_write = 1, reg_dst = 1, mem_to_reg = 0. Retires.
- BRANCH (8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, pc_en = zero. Retires.
- JUMP (9): pc_source = 10, pc_en = 1. Retires.
- ADDIEX (10): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDIWB.
- ADDIWB (11): reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retires.
- HALT (12): all enables 0, halted = 1. Left only by Reset.
- Codes 13–15 are unreachable. If entered, go to HALT with fault = 01.
- Retire: next state = FETCH and instr_count += 1 (wraps modulo 2^CNT_W).
- Zero-wait latency in cycles: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each wait cycle in FETCH/MEMRD/MEMWR adds 1.
- Wait counter:
  - Cleared on entry to any memory state and whenever mem_ready = 1.
  - Increments every cycle the FSM stays in FETCH/MEMRD/MEMWR with mem_ready = 0.
  - When it reaches WAIT_MAX with mem_ready still 0, next state = HALT and fault = 10.
  - mem_ready = 1 in the same cycle as the limit wins (access completes).
- mem_ready is ignored outside memory states.
- fault is sticky until Reset.
- Reset asserted mid-instruction aborts it. No write enable may be asserted in the reset cycle, and instr_count is not incremented.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings (FETCH..HALT);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - funct constants;
  - ALUOp, ALUSrcB, PCSource and fault codes.
- One natural sub-module: mc_op_decode, purely combinational. Maps opcode/funct to the DECODE successor state plus an illegal flag.

Test Plan:
- Reset high for 3 cycles mid-FETCH, mem_ready = 1 → all enables 0, state = 0, instr_count = 0. After release: pc_en = 1 and ir_write = 1 in the first cycle.
- Instruction sequence with mem_ready tied to 1:
  - R-type add (op 000000, funct 100000) → states 0,1,6,7. reg_write = 1 and reg_dst = 1 in cycle 4; instr_count = 1.
  - lw then sw → 5 cycles then 4 cycles; iord = 1 in MEMRD and MEMWR; instr_count = 3.
- beq (op 000100) with zero = 1, then with zero = 0 → pc_en = 1, then 0, in cycle 3 with pc_source = 01. j → pc_en = 1 with pc_source = 10.
- mem_ready = 0 for 4 cycles in FETCH, then 1 → ir_write asserted only in cycle 5, no fault. Holding mem_ready = 0 for WAIT_MAX = 15 cycles in MEMRD → HALT, fault = 10, halted = 1.
- Illegal opcode 111111, then R-type with funct 000000 after Reset → HALT from DECODE, fault = 01, instr_count unchanged, no write enables asserted.
- Preload instr_count = 0xFFFFFFFF (force), retire one addi → instr_count = 0.
